// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: command codes, ALU opcodes
// and FSM state encoding.
package alu_seq_pkg;

    localparam logic [3:0] CMD_ADD   = 4'd0;
    localparam logic [3:0] CMD_SUB   = 4'd1;
    localparam logic [3:0] CMD_AND   = 4'd2;
    localparam logic [3:0] CMD_OR    = 4'd3;
    localparam logic [3:0] CMD_XOR   = 4'd4;
    localparam logic [3:0] CMD_NOR   = 4'd5;
    localparam logic [3:0] CMD_MUL   = 4'd6;
    localparam logic [3:0] CMD_CMPEQ = 4'd7;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOR = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_e;

    // Codes 8-15 have no meaning; bit 3 alone identifies them.
    function automatic logic cmd_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-drive signals of the sequencer. master is the
// sequencer side, slave is the control path / ALU / consumer side.
interface alu_sequencer_if #(parameter int WIDTH = 32);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_zero, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_zero, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_seq_mul_ctrl.sv
// Shift-and-add multiply control: multiplicand/multiplier shift registers and
// the step counter. The accumulator lives in the top.
module alu_seq_mul_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic [WIDTH-1:0] mcand,
    output logic             mul_add_en,
    output logic             mul_done
);

    localparam int CNT_W = $clog2(MUL_STEPS + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    assign mcand      = mcand_q;
    assign mul_add_en = mplier_q[0];
    // Asserted during the final step so the top can retire the result that cycle.
    assign mul_done   = (cnt_q == CNT_W'(MUL_STEPS - 1));

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the combinational ALU: runs single ALU ops, CMPEQ
// via subtract + zero flag, and MUL as a fixed-length shift-and-add loop.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.master  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             mul_load, mul_step, mul_add_en, mul_done;
    logic [WIDTH-1:0] mcand;

    alu_seq_mul_ctrl #(.WIDTH(WIDTH), .MUL_STEPS(MUL_STEPS)) u_mul_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mul_load),
        .step       (mul_step),
        .mcand_in   (bus.cmd_a),
        .mplier_in  (bus.cmd_b),
        .mcand      (mcand),
        .mul_add_en (mul_add_en),
        .mul_done   (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        acc_d      = acc_q;
        res_d      = res_q;
        zero_d     = zero_q;
        err_d      = err_q;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = ALU_ADD;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    a_d   = bus.cmd_a;
                    b_d   = bus.cmd_b;
                    op_d  = bus.cmd_op;
                    err_d = 1'b0;
                    if (cmd_illegal(bus.cmd_op)) begin
                        res_d   = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (bus.cmd_op == CMD_MUL) begin
                        acc_d    = '0;
                        mul_load = 1'b1;
                        state_d  = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                bus.alu_a  = a_q;
                bus.alu_b  = b_q;
                bus.alu_op = op_q[2:0];
                res_d      = bus.alu_result;
                // Equality is a subtract whose zero flag becomes the result.
                if (op_q == CMD_CMPEQ) begin
                    bus.alu_op = ALU_SUB;
                    res_d      = {{(WIDTH-1){1'b0}}, bus.alu_zero};
                end
                zero_d  = (res_d == '0);
                state_d = RESP;
            end
            MUL: begin
                bus.alu_a = acc_q;
                bus.alu_b = mcand;
                mul_step  = 1'b1;
                if (mul_add_en) acc_d = bus.alu_result;
                if (mul_done) begin
                    res_d   = acc_d;
                    zero_d  = (acc_d == '0);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural combinational ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_sequencer_if #(.WIDTH(W)) bus();

    alu_sequencer #(.WIDTH(W), .MUL_STEPS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The ALU the sequencer drives
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_result = bus.alu_a | bus.alu_b;
            3'b100: bus.alu_result = bus.alu_a ^ bus.alu_b;
            3'b101: bus.alu_result = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        x.err = 1'b0;
        x.lat = 2;
        x.res = '0;
        case (op)
            4'd0: x.res = a + b;
            4'd1: x.res = a - b;
            4'd2: x.res = a & b;
            4'd3: x.res = a | b;
            4'd4: x.res = a ^ b;
            4'd5: x.res = ~(a | b);
            4'd6: begin x.res = a * b; x.lat = 33; end
            4'd7: x.res = (a == b) ? 32'd1 : 32'd0;
            default: begin x.res = '0; x.err = 1'b1; x.lat = 1; end
        endcase
        x.zero = (x.res == '0);
        return x;
    endfunction

    // Issue one command with rsp_ready high, return what the DUT responded.
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output logic [W-1:0] res, output logic z, output logic e);
        sb.push_back(model(op, a, b));
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.rsp_result;
        z = bus.rsp_zero;
        e = bus.rsp_err;
        if (bus.rsp_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 8;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready got %b want 1", bus.cmd_ready); end
        if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset rsp_valid got %b want 0", bus.rsp_valid); end
        if (bus.rsp_result !== '0) begin failures++; $display("FAIL reset rsp_result got %h want 0", bus.rsp_result); end
        if (bus.rsp_zero !== 1'b0) begin failures++; $display("FAIL reset rsp_zero got %b want 0", bus.rsp_zero); end
        if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset rsp_err got %b want 0", bus.rsp_err); end
        if (bus.alu_a !== '0) begin failures++; $display("FAIL reset alu_a got %h want 0", bus.alu_a); end
        if (bus.alu_b !== '0) begin failures++; $display("FAIL reset alu_b got %h want 0", bus.alu_b); end
        if (bus.alu_op !== 3'b000) begin failures++; $display("FAIL reset alu_op got %b want 000", bus.alu_op); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ops();
        logic [3:0]   ops[7] = '{4'd0, 4'd5, 4'd4, 4'd1, 4'd2, 4'd3, 4'd0};
        logic [W-1:0] as[7]  = '{32'hFFFF_FFFF, 32'h0F0F_0000, 32'h1234, 32'd5, 32'hF0F0_F0F0, 32'h00FF_0000, 32'h0};
        logic [W-1:0] bs[7]  = '{32'h1, 32'h00F0_0000, 32'h1234, 32'd7, 32'h3C3C_3C3C, 32'h0000_FF00, 32'h0};
        int lat;
        logic [W-1:0] res;
        logic z, e;
        exp_t x;
        as[6] = $urandom;
        bs[6] = $urandom;
        for (int i = 0; i < 7; i++) begin
            run_cmd(ops[i], as[i], bs[i], lat, res, z, e);
            x = sb.pop_front();
            checks += 4;
            if (lat != x.lat) begin failures++; $display("FAIL alu_op%0d latency got %0d want %0d", ops[i], lat, x.lat); end
            if (res !== x.res) begin failures++; $display("FAIL alu_op%0d result got %h want %h", ops[i], res, x.res); end
            if (z !== x.zero) begin failures++; $display("FAIL alu_op%0d zero got %b want %b", ops[i], z, x.zero); end
            if (e !== x.err) begin failures++; $display("FAIL alu_op%0d err got %b want %b", ops[i], e, x.err); end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] as[4] = '{32'd1234, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        logic [W-1:0] bs[4] = '{32'd5678, 32'd2, 32'hFFFF_FFFF, 32'h0};
        int lat;
        logic [W-1:0] res;
        logic z, e;
        exp_t x;
        as[3] = $urandom;
        bs[3] = $urandom;
        for (int i = 0; i < 4; i++) begin
            run_cmd(CMD_MUL, as[i], bs[i], lat, res, z, e);
            x = sb.pop_front();
            checks += 4;
            if (lat != x.lat) begin failures++; $display("FAIL mul%0d latency got %0d want %0d", i, lat, x.lat); end
            if (res !== x.res) begin failures++; $display("FAIL mul%0d result got %h want %h", i, res, x.res); end
            if (z !== x.zero) begin failures++; $display("FAIL mul%0d zero got %b want %b", i, z, x.zero); end
            if (e !== x.err) begin failures++; $display("FAIL mul%0d err got %b want %b", i, e, x.err); end
        end
    endtask

    task automatic test_cmpeq_illegal();
        logic [3:0]   ops[5] = '{4'd7, 4'd7, 4'd9, 4'd15, 4'd8};
        logic [W-1:0] as[5]  = '{32'hDEAD, 32'd1, 32'h55, 32'hFFFF_FFFF, 32'd3};
        logic [W-1:0] bs[5]  = '{32'hDEAD, 32'd2, 32'h66, 32'd1, 32'd3};
        int lat;
        logic [W-1:0] res;
        logic z, e;
        exp_t x;
        for (int i = 0; i < 5; i++) begin
            run_cmd(ops[i], as[i], bs[i], lat, res, z, e);
            x = sb.pop_front();
            checks += 4;
            if (lat != x.lat) begin failures++; $display("FAIL cmp_ill%0d latency got %0d want %0d", i, lat, x.lat); end
            if (res !== x.res) begin failures++; $display("FAIL cmp_ill%0d result got %h want %h", i, res, x.res); end
            if (z !== x.zero) begin failures++; $display("FAIL cmp_ill%0d zero got %b want %b", i, z, x.zero); end
            if (e !== x.err) begin failures++; $display("FAIL cmp_ill%0d err got %b want %b", i, e, x.err); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] res, a, b;
        logic [3:0] op;
        logic z, e;
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 9));
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            checks++;
            if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d cmd_ready got %b want 1", i, bus.cmd_ready); end
            run_cmd(op, a, b, lat, res, z, e);
            x = sb.pop_front();
            checks += 4;
            if (lat != x.lat) begin failures++; $display("FAIL b2b%0d op%0d latency got %0d want %0d", i, op, lat, x.lat); end
            if (res !== x.res) begin failures++; $display("FAIL b2b%0d op%0d result got %h want %h", i, op, res, x.res); end
            if (z !== x.zero) begin failures++; $display("FAIL b2b%0d op%0d zero got %b want %b", i, op, z, x.zero); end
            if (e !== x.err) begin failures++; $display("FAIL b2b%0d op%0d err got %b want %b", i, op, e, x.err); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t x;
        bus.rsp_ready = 1'b0;
        sb.push_back(model(CMD_ADD, 32'h10, 32'h20));
        bus.cmd_op = CMD_ADD;
        bus.cmd_a = 32'h10;
        bus.cmd_b = 32'h20;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        x = sb.pop_front();
        checks++;
        if (lat != x.lat) begin failures++; $display("FAIL bp latency got %0d want %0d", lat, x.lat); end
        // Second command held while the first response is stalled
        sb.push_back(model(CMD_XOR, 32'hAA, 32'h55));
        bus.cmd_op = CMD_XOR;
        bus.cmd_a = 32'hAA;
        bus.cmd_b = 32'h55;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks += 4;
            if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp hold%0d rsp_valid got %b want 1", i, bus.rsp_valid); end
            if (bus.rsp_result !== x.res) begin failures++; $display("FAIL bp hold%0d result got %h want %h", i, bus.rsp_result, x.res); end
            if (bus.rsp_zero !== x.zero) begin failures++; $display("FAIL bp hold%0d zero got %b want %b", i, bus.rsp_zero, x.zero); end
            if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp hold%0d cmd_ready got %b want 0", i, bus.cmd_ready); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp release rsp_valid got %b want 0", bus.rsp_valid); end
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL bp release cmd_ready got %b want 1", bus.cmd_ready); end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp accept cmd_ready got %b want 0", bus.cmd_ready); end
        @(posedge clk); #1;
        x = sb.pop_front();
        checks += 3;
        if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp second rsp_valid got %b want 1", bus.rsp_valid); end
        if (bus.rsp_result !== x.res) begin failures++; $display("FAIL bp second result got %h want %h", bus.rsp_result, x.res); end
        if (bus.rsp_err !== x.err) begin failures++; $display("FAIL bp second err got %b want %b", bus.rsp_err, x.err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        int lat;
        logic [W-1:0] res;
        logic z, e;
        exp_t x;
        bus.cmd_op = CMD_MUL;
        bus.cmd_a = 32'd3;
        bus.cmd_b = 32'd5;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort cmd_ready got %b want 1", bus.cmd_ready); end
        if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL abort rsp_valid got %b want 0", bus.rsp_valid); end
        if (bus.rsp_result !== '0) begin failures++; $display("FAIL abort rsp_result got %h want 0", bus.rsp_result); end
        if (bus.alu_a !== '0) begin failures++; $display("FAIL abort alu_a got %h want 0", bus.alu_a); end
        if (bus.alu_b !== '0) begin failures++; $display("FAIL abort alu_b got %h want 0", bus.alu_b); end
        if (bus.alu_op !== 3'b000) begin failures++; $display("FAIL abort alu_op got %b want 000", bus.alu_op); end
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        checks += 2;
        if (seen != 0) begin failures++; $display("FAIL abort spurious rsp_valid cycles got %0d want 0", seen); end
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort idle cmd_ready got %b want 1", bus.cmd_ready); end
        run_cmd(CMD_SUB, 32'd100, 32'd58, lat, res, z, e);
        x = sb.pop_front();
        checks += 2;
        if (lat != x.lat) begin failures++; $display("FAIL abort after latency got %0d want %0d", lat, x.lat); end
        if (res !== x.res) begin failures++; $display("FAIL abort after result got %h want %h", res, x.res); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_cmpeq_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
